// File: rtl/multicycle_alu.sv
// RV32I-style ALU with an optional iterative M-extension unit behind a valid/ready handshake.
// Define MULDIV_EN to build the shift-add multiplier and restoring divider.
module multicycle_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      ALU_Control,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_Result,
    output logic            Zero
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state;
    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] quick_result;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign shamt     = B[SHW-1:0];

`ifdef MULDIV_EN
    localparam logic [1:0]      S_MUL    = 2'd1;
    localparam logic [1:0]      S_DIV    = 2'd2;
    localparam logic [SHW-1:0]  LAST     = SHW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   operand;
    logic [SHW-1:0]    cnt;
    logic [4:0]        op_q;
    logic              neg_q;
    logic              rem_neg_q;

    logic              is_mul, is_div, div_special;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, mul_prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     div_shift, div_trial;
    logic              div_ok;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   div_quo, div_rem, div_res;

    assign is_mul      = ALU_Control inside {[5'd10:5'd13]};
    assign is_div      = ALU_Control inside {[5'd14:5'd17]};
    assign div_special = (B == '0) ||
                         ((ALU_Control == 5'd14 || ALU_Control == 5'd16) && A == MOST_NEG && B == '1);

    // Iterations run on magnitudes; the recorded signs are re-applied on the final step.
    assign sign_a = A[XLEN-1] && (ALU_Control == 5'd11 || ALU_Control == 5'd12 ||
                                  ALU_Control == 5'd14 || ALU_Control == 5'd16);
    assign sign_b = B[XLEN-1] && (ALU_Control == 5'd11 || ALU_Control == 5'd14 ||
                                  ALU_Control == 5'd16);
    assign mag_a  = sign_a ? -A : A;
    assign mag_b  = sign_b ? -B : B;

    // Multiplier: low half of acc holds the remaining multiplier bits, high half the partial sum.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};
    assign mul_prod = neg_q ? -mul_next : mul_next;
    assign mul_res  = (op_q == 5'd10) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    // Divider: high half is the partial remainder, low half shifts dividend out and quotient in.
    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_trial = div_shift - {1'b0, operand};
    assign div_ok    = !div_trial[XLEN];
    assign div_next  = {div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0], acc[XLEN-2:0], div_ok};
    assign div_quo   = neg_q ? -(div_next[XLEN-1:0]) : div_next[XLEN-1:0];
    assign div_rem   = rem_neg_q ? -(div_next[2*XLEN-1:XLEN]) : div_next[2*XLEN-1:XLEN];
    assign div_res   = op_q[4] ? div_rem : div_quo;
`endif

    always_comb begin
        quick_result = '0;
        case (ALU_Control)
            5'd0:    quick_result = A + B;
            5'd1:    quick_result = A - B;
            5'd2:    quick_result = A & B;
            5'd3:    quick_result = A | B;
            5'd4:    quick_result = A ^ B;
            5'd5:    quick_result = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
            5'd6:    quick_result = A << shamt;
            5'd7:    quick_result = A >> shamt;
            5'd8:    quick_result = $signed(A) >>> shamt;
            5'd9:    quick_result = {{(XLEN-1){1'b0}}, A < B};
`ifdef MULDIV_EN
            5'd14, 5'd15: begin
                if (B == '0)
                    quick_result = '1;
                else
                    quick_result = A;
            end
            5'd16, 5'd17: begin
                if (B == '0)
                    quick_result = A;
                else
                    quick_result = '0;
            end
`endif
            default: quick_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ALU_Result <= '0;
            Zero       <= 1'b1;
`ifdef MULDIV_EN
            acc        <= '0;
            operand    <= '0;
            cnt        <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
`ifdef MULDIV_EN
                        op_q      <= ALU_Control;
                        cnt       <= '0;
                        neg_q     <= sign_a ^ sign_b;
                        rem_neg_q <= sign_a;
                        if (is_mul) begin
                            state   <= S_MUL;
                            acc     <= {{XLEN{1'b0}}, mag_b};
                            operand <= mag_a;
                        end else if (is_div && !div_special) begin
                            state   <= S_DIV;
                            acc     <= {{XLEN{1'b0}}, mag_a};
                            operand <= mag_b;
                        end else begin
                            state      <= S_DONE;
                            ALU_Result <= quick_result;
                            Zero       <= (quick_result == '0);
                        end
`else
                        state      <= S_DONE;
                        ALU_Result <= quick_result;
                        Zero       <= (quick_result == '0);
`endif
                    end
                end
`ifdef MULDIV_EN
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state      <= S_DONE;
                        ALU_Result <= mul_res;
                        Zero       <= (mul_res == '0);
                    end
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state      <= S_DONE;
                        ALU_Result <= div_res;
                        Zero       <= (div_res == '0);
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed literal cases, reset abort, then randomized
// traffic compared every cycle against a behavioural model of results and latencies.
module tb_multicycle_alu;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  ALU_Control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALU_Result;
    logic        Zero;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic rand_ready = 1'b0;

    multicycle_alu dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ALU_Control(ALU_Control),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALU_Result (ALU_Result),
        .Zero       (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference behaviour: plain 64-bit arithmetic on the architectural definitions.
    task automatic refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output int lat);
`ifdef MULDIV_EN
        longint sa, sb, zb, p;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        zb = {32'd0, b};
        p  = 0;
        up = 0;
`endif
        lat = 1;
        res = 32'd0;
        case (op)
            5'd0: res = a + b;
            5'd1: res = a - b;
            5'd2: res = a & b;
            5'd3: res = a | b;
            5'd4: res = a ^ b;
            5'd5: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd6: res = a << b[4:0];
            5'd7: res = a >> b[4:0];
            5'd8: res = $signed(a) >>> b[4:0];
            5'd9: res = (a < b) ? 32'd1 : 32'd0;
`ifdef MULDIV_EN
            5'd10: begin p = sa * sb; res = p[31:0]; lat = 33; end
            5'd11: begin p = sa * sb; res = p[63:32]; lat = 33; end
            5'd12: begin p = sa * zb; res = p[63:32]; lat = 33; end
            5'd13: begin up = {32'd0, a} * {32'd0, b}; res = up[63:32]; lat = 33; end
            5'd14: begin
                if (b == 32'd0) res = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = a;
                else begin p = sa / sb; res = p[31:0]; lat = 33; end
            end
            5'd15: begin
                if (b == 32'd0) res = 32'hFFFFFFFF;
                else begin res = a / b; lat = 33; end
            end
            5'd16: begin
                if (b == 32'd0) res = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = 32'd0;
                else begin p = sa % sb; res = p[31:0]; lat = 33; end
            end
            5'd17: begin
                if (b == 32'd0) res = a;
                else begin res = a % b; lat = 33; end
            end
`endif
            default: res = 32'd0;
        endcase
    endtask

    // Call one time unit after a rising edge; returns one time unit after the accept edge.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   waitc = 0;
        A = a;
        B = b;
        ALU_Control = op;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waitc < 200) begin
            waitc++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checkOutput("accept timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        #1;
        refModel(op, a, b, e.res, e.lat);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        ALU_Control = 5'($urandom);
    endtask

    task automatic runDirected(input string name, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat = 0;
        out_ready = 1'b0;
        applyStimulus(op, a, b);
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, " result"}, ALU_Result, exp_res);
        repeat (3) @(negedge clk);
        checkOutput({name, " held"}, ALU_Result, exp_res);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // One compare process: handshake flags, result and Zero against the model queue every cycle.
    initial begin
        logic exp_valid;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_valid = 1'b0;
                if (exp_q.size() != 0)
                    exp_valid = (cyc - exp_q[0].acc_cyc + 1 >= exp_q[0].lat);
                checkOutput("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
                checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
                if (exp_valid && out_valid) begin
                    checkOutput("model result", ALU_Result, exp_q[0].res);
                    checkOutput("model zero", 32'(Zero), 32'(exp_q[0].res == 32'd0));
                    if (out_ready)
                        void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready)
                out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        int waitc;
        logic [31:0] ra, rb;
        logic [4:0]  rop;

        rst = 1'b1;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        ALU_Control = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset result", ALU_Result, 32'd0);
        checkOutput("reset zero", 32'(Zero), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("post-reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("post-reset zero", 32'(Zero), 32'd1);
        @(posedge clk);
        #1;

        runDirected("ADD 5+7", 5'd0, 32'd5, 32'd7, 32'd12, 1);
        checkOutput("ADD zero", 32'(Zero), 32'd0);
        runDirected("SUB 5-5", 5'd1, 32'd5, 32'd5, 32'd0, 1);
        runDirected("SLT", 5'd5, 32'hFFFFFFFF, 32'd1, 32'd1, 1);
        runDirected("SLTU", 5'd9, 32'hFFFFFFFF, 32'd1, 32'd0, 1);
        runDirected("SRA", 5'd8, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1);
        runDirected("SLL by 33", 5'd6, 32'h00000003, 32'd33, 32'h00000006, 1);
        runDirected("undefined op", 5'd20, 32'd9, 32'd9, 32'd0, 1);
`ifdef MULDIV_EN
        runDirected("MUL", 5'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
        runDirected("MULHU", 5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        runDirected("MULH", 5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        runDirected("MULHSU", 5'd12, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
        runDirected("DIV -7/2", 5'd14, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        runDirected("REM -7%2", 5'd16, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        runDirected("DIVU by 0", 5'd15, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
        runDirected("REM by 0", 5'd16, 32'd9, 32'd0, 32'd9, 1);
        runDirected("DIV overflow", 5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
`else
        runDirected("MUL disabled", 5'd10, 32'd3, 32'd4, 32'd0, 1);
`endif

        // Abort a divide ten cycles in; nothing may emerge afterwards.
        runDirected("ADD before abort", 5'd0, 32'd40, 32'd2, 32'd42, 1);
        applyStimulus(5'd14, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("abort in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort result", ALU_Result, 32'd0);
        checkOutput("abort zero", 32'(Zero), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("abort no out_valid", 32'(seen), 32'd0);
        @(posedge clk);
        #1;

        rand_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 7) rop = 5'($urandom_range(0, 17));
            else rop = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 7))
                0: ra = 32'h80000000;
                1: ra = 32'd0;
                2: ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = $urandom_range(0, 40);
                default: rb = $urandom;
            endcase
            applyStimulus(rop, ra, rb);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        waitc = 0;
        while (exp_q.size() != 0 && waitc < 200) begin
            @(posedge clk);
            waitc++;
        end
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
        rand_ready = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
